// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB memory slave: FSM states, response codes,
// and index-width helpers derived from the bus and memory geometry.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    // Number of PADDR bits that select a byte within one data word.
    function automatic int lane_bits(input int data_w);
        int nb;
        nb = data_w / 8;
        return (nb > 1) ? $clog2(nb) : 0;
    endfunction

    // Word-index width for a bank of the given depth (never zero).
    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// DEPTH x DATA_W flop storage cleared by async reset, with one byte-enabled
// write port and one combinational read port.
module apb_mem_bank
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int NB     = DATA_W / 8,
    parameter int AW     = idx_bits(DEPTH)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     wstrb,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < DEPTH)) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) mem_q <= '0;
        else          mem_q <= mem_d;
    end

    // Indices past DEPTH only arise for errored accesses; return zero for them.
    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: setup/access FSM with programmable wait states, address
// decode with error response and a read-only low region, backed by apb_mem_bank.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 0,
    parameter int NB          = DATA_W / 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [NB-1:0]     PSTRB,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int LANE_W = lane_bits(DATA_W);
    localparam int IDX_AW = idx_bits(DEPTH);

    apb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_AW-1:0] idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     strb_q, strb_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic [ADDR_W-1:0] idx_c;
    logic              mis_c, err_c, setup_c, ready_c, mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Setup-phase decode, evaluated on the live bus.
    assign idx_c   = PADDR >> LANE_W;
    assign mis_c   = (PADDR & ADDR_W'(NB - 1)) != '0;
    assign err_c   = mis_c || (int'(idx_c) >= DEPTH) || (PWRITE && (int'(idx_c) < RO_WORDS));
    assign setup_c = PSEL && !PENABLE;
    assign ready_c = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rd_d    = rd_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup_c) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    idx_d   = IDX_AW'(idx_c);
                    wr_d    = PWRITE;
                    err_d   = err_c;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    rd_d    = err_c ? '0 : mem_rdata;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE && ready_c) begin
                    mem_we  = wr_q && !err_q;
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rd_q    <= rd_d;
        end
    end

    apb_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NB     (NB),
        .AW     (IDX_AW)
    ) u_bank (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (mem_we),
        .waddr   (idx_q),
        .wdata   (wdata_q),
        .wstrb   (strb_q),
        .raddr   (IDX_AW'(idx_c)),
        .rdata   (mem_rdata)
    );

    assign PREADY  = ready_c;
    assign PSLVERR = (ready_c && err_q) ? APB_ERR : APB_OKAY;
    assign PRDATA  = (ready_c && !wr_q && !err_q) ? rd_q : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: three slaves (0, 3 and 2 wait states) share one APB bus with
// separate selects; transfers are checked against hand-computed values.
module tb_apb_mem_slave;

    logic              PCLK;
    logic              PRESETn;
    logic [2:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [9:0]        paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [2:0][31:0]  prdata;
    logic [2:0]        pready;
    logic [2:0]        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    localparam int D0 = 0;  // 0 waits, RO_WORDS=2
    localparam int D3 = 1;  // 3 waits
    localparam int D2 = 2;  // 2 waits

    apb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(64), .WAIT_CYCLES(0), .RO_WORDS(2)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(64), .WAIT_CYCLES(3), .RO_WORDS(0)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(64), .WAIT_CYCLES(2), .RO_WORDS(0)) u_dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transfer, entered and left #1 after a rising edge.
    // While waiting, PRDATA and PSLVERR must stay low.
    task automatic xfer(input int d, input logic wr, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int waits);
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = strb;
        @(posedge PCLK); #1;
        penable = 1'b1;
        waits   = 0;
        while (!pready[d] && waits < 20) begin
            chk("wait_prdata", prdata[d], 32'h0);
            chk("wait_pslverr", {31'b0, pslverr[d]}, 32'h0);
            @(posedge PCLK); #1;
            waits++;
        end
        if (!pready[d]) chk("pready_timeout", 32'h0, 32'h1);
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge PCLK); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input int d, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          waits;
        xfer(d, 1'b1, addr, wd, strb, rd, err, waits);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    endtask

    task automatic rd_chk(input string tag, input int d, input logic [9:0] addr,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          waits;
        xfer(d, 1'b0, addr, 32'h0, 4'h0, rd, err, waits);
        chk({tag, "_data"}, rd, exp_data);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_pready", {29'b0, pready}, 32'h0);
        chk("rst_pslverr", {29'b0, pslverr}, 32'h0);
        chk("rst_prdata0", prdata[0], 32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Reset in the middle of a waited write to word 3.
        psel[D3] = 1'b1; pwrite = 1'b1; paddr = 10'h00C; pwdata = 32'h5555_5555; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #1;
        PRESETn = 1'b0;
        #1;
        chk("midrst_pready", {31'b0, pready[D3]}, 32'h0);
        chk("midrst_pslverr", {31'b0, pslverr[D3]}, 32'h0);
        chk("midrst_prdata", prdata[D3], 32'h0);
        psel = 3'b000; penable = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        rd_chk("midrst_rd3", D3, 10'h00C, 32'h0, 1'b0, 3);

        // Zero-wait write/read.
        wr_chk("w10", D0, 10'h010, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
        rd_chk("r10", D0, 10'h010, 32'hDEAD_BEEF, 1'b0, 0);

        // Byte strobes, back-to-back.
        wr_chk("w20a", D0, 10'h020, 32'h1122_3344, 4'hF, 1'b0, 0);
        wr_chk("w20b", D0, 10'h020, 32'hAABB_CCDD, 4'b0101, 1'b0, 0);
        rd_chk("r20", D0, 10'h020, 32'h11BB_33DD, 1'b0, 0);
        wr_chk("w10s0", D0, 10'h010, 32'h0000_0000, 4'h0, 1'b0, 0);
        rd_chk("r10s0", D0, 10'h010, 32'hDEAD_BEEF, 1'b0, 0);

        // Three wait states.
        wr_chk("w3", D3, 10'h008, 32'h1234_5678, 4'hF, 1'b0, 3);
        rd_chk("r3", D3, 10'h008, 32'h1234_5678, 1'b0, 3);

        // Error responses.
        rd_chk("e_mis102", D0, 10'h102, 32'h0, 1'b1, 0);
        rd_chk("e_depth", D0, 10'h100, 32'h0, 1'b1, 0);
        rd_chk("e_mis11", D0, 10'h011, 32'h0, 1'b1, 0);
        wr_chk("e_ro", D0, 10'h004, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);
        rd_chk("ro_rd", D0, 10'h004, 32'h0, 1'b0, 0);
        wr_chk("e_ro3w", D3, 10'h0FE, 32'hFFFF_FFFF, 4'hF, 1'b1, 3);
        rd_chk("r10_after_err", D0, 10'h010, 32'hDEAD_BEEF, 1'b0, 0);

        // Abort a waited write by dropping PSEL in its first access cycle.
        wr_chk("w14", D2, 10'h014, 32'hCAFE_F00D, 4'hF, 1'b0, 2);
        psel[D2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h014;
        pwdata = 32'h0BAD_BEEF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        chk("abort_pready", {31'b0, pready[D2]}, 32'h0);
        psel = 3'b000; penable = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_idle_pready", {31'b0, pready[D2]}, 32'h0);
        rd_chk("abort_r14", D2, 10'h014, 32'hCAFE_F00D, 1'b0, 2);
        wr_chk("b2b_w18", D2, 10'h018, 32'h0102_0304, 4'hF, 1'b0, 2);
        rd_chk("b2b_r18", D2, 10'h018, 32'h0102_0304, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
